// File: rtl/id_stage_if.sv
// Decode-stage bus: fetch-side request/response and execute-side decoded outputs.
// master = the environment around the stage, slave = id_stage itself.
interface id_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] in_pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        ex_ready;
  logic        out_valid;
  logic        alu_src_a;
  logic        alu_src_b;
  logic        is_signed;
  logic [3:0]  alu_op;
  logic [31:0] pc;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] sext;
  logic [4:0]  rd;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic        illegal;

  modport master (
    output in_valid, instr, in_pc, rs1_data, rs2_data, ex_ready,
    input  in_ready, out_valid, alu_src_a, alu_src_b, is_signed, alu_op,
           pc, a, b, sext, rd, reg_write, mem_read, mem_write, illegal
  );

  modport slave (
    input  in_valid, instr, in_pc, rs1_data, rs2_data, ex_ready,
    output in_ready, out_valid, alu_src_a, alu_src_b, is_signed, alu_op,
           pc, a, b, sext, rd, reg_write, mem_read, mem_write, illegal
  );
endinterface

// File: rtl/id_stage.sv
// RV32I decode stage: combinational decoder feeding a single-entry output register
// with valid/ready handshake, flush and synchronous active-low reset.
module id_stage (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  id_stage_if.slave  bus
);
  localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_SLL = 4'd2,  OP_SLT = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4,  OP_SRL = 4'd5,  OP_SRA = 4'd6,  OP_OR  = 4'd7;
  localparam logic [3:0] OP_AND = 4'd8,  OP_BEQ = 4'd9,  OP_BNE = 4'd10, OP_BLT = 4'd11;
  localparam logic [3:0] OP_BGE = 4'd12, OP_PASSB = 4'd13;

  logic [6:0]  opcode_s, funct7_s;
  logic [2:0]  funct3_s;
  logic [4:0]  rd_s;
  logic [31:0] imm_i_s, imm_s_s, imm_b_s, imm_u_s, imm_j_s;
  logic [3:0]  dec_op_s;
  logic [31:0] dec_sext_s;
  logic        dec_src_a_s, dec_src_b_s, dec_signed_s;
  logic        dec_rw_s, dec_mr_s, dec_mw_s, dec_ill_s;
  logic        fin_rw_s, fin_mr_s, fin_mw_s;
  logic        in_ready_s, accept_s;

  logic        out_valid_r, alu_src_a_r, alu_src_b_r, is_signed_r;
  logic [3:0]  alu_op_r;
  logic [31:0] pc_r, a_r, b_r, sext_r;
  logic [4:0]  rd_r;
  logic        reg_write_r, mem_read_r, mem_write_r, illegal_r;

  assign opcode_s = bus.instr[6:0];
  assign funct3_s = bus.instr[14:12];
  assign funct7_s = bus.instr[31:25];
  assign rd_s     = bus.instr[11:7];
  assign imm_i_s  = {{20{bus.instr[31]}}, bus.instr[31:20]};
  assign imm_s_s  = {{20{bus.instr[31]}}, bus.instr[31:25], bus.instr[11:7]};
  assign imm_b_s  = {{19{bus.instr[31]}}, bus.instr[31], bus.instr[7],
                     bus.instr[30:25], bus.instr[11:8], 1'b0};
  assign imm_u_s  = {bus.instr[31:12], 12'd0};
  assign imm_j_s  = {{11{bus.instr[31]}}, bus.instr[31], bus.instr[19:12],
                     bus.instr[20], bus.instr[30:21], 1'b0};

  // Instruction decoder: control fields and immediate for the incoming word.
  always_comb begin
    dec_op_s     = OP_ADD;
    dec_sext_s   = 32'd0;
    dec_src_a_s  = 1'b0;
    dec_src_b_s  = 1'b0;
    dec_signed_s = 1'b0;
    dec_rw_s     = 1'b0;
    dec_mr_s     = 1'b0;
    dec_mw_s     = 1'b0;
    dec_ill_s    = 1'b0;
    case (opcode_s)
      7'b0110011: begin
        dec_src_a_s = 1'b1;
        dec_rw_s    = 1'b1;
        // Only funct7 = 0x00, or 0x20 paired with SUB/SRA, exist in RV32I.
        if ((funct7_s == 7'b0000000) ||
            ((funct7_s == 7'b0100000) && ((funct3_s == 3'b000) || (funct3_s == 3'b101)))) begin
          case (funct3_s)
            3'b000:  dec_op_s = funct7_s[5] ? OP_SUB : OP_ADD;
            3'b001:  dec_op_s = OP_SLL;
            3'b010:  begin dec_op_s = OP_SLT; dec_signed_s = 1'b1; end
            3'b011:  dec_op_s = OP_SLT;
            3'b100:  dec_op_s = OP_XOR;
            3'b101:  dec_op_s = funct7_s[5] ? OP_SRA : OP_SRL;
            3'b110:  dec_op_s = OP_OR;
            3'b111:  dec_op_s = OP_AND;
            default: dec_ill_s = 1'b1;
          endcase
        end else begin
          dec_ill_s = 1'b1;
        end
      end
      7'b0010011: begin
        dec_src_a_s = 1'b1;
        dec_src_b_s = 1'b1;
        dec_sext_s  = imm_i_s;
        dec_rw_s    = 1'b1;
        case (funct3_s)
          3'b000:  dec_op_s = OP_ADD;
          3'b001:  begin
            dec_op_s = OP_SLL;
            if (funct7_s != 7'b0000000) dec_ill_s = 1'b1;
            else                        dec_ill_s = 1'b0;
          end
          3'b010:  begin dec_op_s = OP_SLT; dec_signed_s = 1'b1; end
          3'b011:  dec_op_s = OP_SLT;
          3'b100:  dec_op_s = OP_XOR;
          3'b101:  begin
            if (funct7_s == 7'b0000000)      dec_op_s = OP_SRL;
            else if (funct7_s == 7'b0100000) dec_op_s = OP_SRA;
            else                             dec_ill_s = 1'b1;
          end
          3'b110:  dec_op_s = OP_OR;
          3'b111:  dec_op_s = OP_AND;
          default: dec_ill_s = 1'b1;
        endcase
      end
      7'b0110111: begin
        dec_op_s = OP_PASSB; dec_src_b_s = 1'b1; dec_sext_s = imm_u_s; dec_rw_s = 1'b1;
      end
      7'b0010111: begin
        dec_src_b_s = 1'b1; dec_sext_s = imm_u_s; dec_rw_s = 1'b1;
      end
      7'b0000011: begin
        dec_src_a_s = 1'b1; dec_src_b_s = 1'b1; dec_sext_s = imm_i_s;
        dec_mr_s = 1'b1; dec_rw_s = 1'b1;
      end
      7'b0100011: begin
        dec_src_a_s = 1'b1; dec_src_b_s = 1'b1; dec_sext_s = imm_s_s; dec_mw_s = 1'b1;
      end
      7'b1100011: begin
        dec_src_a_s = 1'b1;
        dec_sext_s  = imm_b_s;
        case (funct3_s)
          3'b000:  dec_op_s = OP_BEQ;
          3'b001:  dec_op_s = OP_BNE;
          3'b100:  begin dec_op_s = OP_BLT; dec_signed_s = 1'b1; end
          3'b101:  begin dec_op_s = OP_BGE; dec_signed_s = 1'b1; end
          3'b110:  dec_op_s = OP_BLT;
          3'b111:  dec_op_s = OP_BGE;
          default: dec_ill_s = 1'b1;
        endcase
      end
      7'b1101111: begin
        dec_src_b_s = 1'b1; dec_sext_s = imm_j_s; dec_rw_s = 1'b1;
      end
      7'b1100111: begin
        if (funct3_s == 3'b000) begin
          dec_src_a_s = 1'b1; dec_src_b_s = 1'b1; dec_sext_s = imm_i_s; dec_rw_s = 1'b1;
        end else begin
          dec_ill_s = 1'b1;
        end
      end
      default: dec_ill_s = 1'b1;
    endcase
  end

  // An illegal word never writes anything; x0 is never written.
  assign fin_rw_s   = dec_rw_s && !dec_ill_s && (rd_s != 5'd0);
  assign fin_mr_s   = dec_mr_s && !dec_ill_s;
  assign fin_mw_s   = dec_mw_s && !dec_ill_s;
  assign in_ready_s = !out_valid_r || bus.ex_ready;
  assign accept_s   = bus.in_valid && in_ready_s;

  // Output pipeline register: reset > flush > accept > consume > hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0; alu_src_a_r <= 1'b0; alu_src_b_r <= 1'b0; is_signed_r <= 1'b0;
      alu_op_r    <= 4'd0; pc_r <= 32'd0; a_r <= 32'd0; b_r <= 32'd0; sext_r <= 32'd0;
      rd_r        <= 5'd0; reg_write_r <= 1'b0; mem_read_r <= 1'b0; mem_write_r <= 1'b0;
      illegal_r   <= 1'b0;
    end else if (flush) begin
      out_valid_r <= 1'b0; reg_write_r <= 1'b0; mem_read_r <= 1'b0; mem_write_r <= 1'b0;
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      alu_src_a_r <= dec_src_a_s; alu_src_b_r <= dec_src_b_s; is_signed_r <= dec_signed_s;
      alu_op_r    <= dec_op_s;    pc_r <= bus.in_pc; a_r <= bus.rs1_data; b_r <= bus.rs2_data;
      sext_r      <= dec_sext_s;  rd_r <= rd_s;
      reg_write_r <= fin_rw_s; mem_read_r <= fin_mr_s; mem_write_r <= fin_mw_s;
      illegal_r   <= dec_ill_s;
    end else if (bus.ex_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.alu_src_a = alu_src_a_r;
  assign bus.alu_src_b = alu_src_b_r;
  assign bus.is_signed = is_signed_r;
  assign bus.alu_op    = alu_op_r;
  assign bus.pc        = pc_r;
  assign bus.a         = a_r;
  assign bus.b         = b_r;
  assign bus.sext      = sext_r;
  assign bus.rd        = rd_r;
  assign bus.reg_write = reg_write_r;
  assign bus.mem_read  = mem_read_r;
  assign bus.mem_write = mem_write_r;
  assign bus.illegal   = illegal_r;
endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: decode vector table streamed back-to-back through a
// scoreboard, then hand-written stall, flush and reset-during-stall sequences.
module tb_id_stage;
  typedef struct {
    logic [31:0] instr;
    logic        ill;
    logic [3:0]  op;
    logic        sa, sb, sg;
    logic [31:0] sext;
    logic [4:0]  rd;
    logic        rw, mr, mw;
    logic        chk_dp, chk_a, chk_sext;
  } vec_t;

  typedef struct {
    vec_t        v;
    logic [31:0] pc, a, b;
  } exp_t;

  logic clk, rst_n, flush;
  id_stage_if bus();

  id_stage dut (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  exp_t held;
  logic ov_m = 1'b0;
  vec_t tbl[26];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(logic [31:0] i, logic il, logic [3:0] op, logic sa, logic sb_,
                               logic sg, logic [31:0] sx, logic [4:0] rd, logic rw, logic mr,
                               logic mw, logic cd, logic ca, logic cs);
    vec_t v;
    v.instr = i; v.ill = il; v.op = op; v.sa = sa; v.sb = sb_; v.sg = sg; v.sext = sx;
    v.rd = rd; v.rw = rw; v.mr = mr; v.mw = mw; v.chk_dp = cd; v.chk_a = ca; v.chk_sext = cs;
    return v;
  endfunction

  task automatic cmp(input exp_t e);
    chk("illegal",   32'(bus.illegal),   32'(e.v.ill));
    chk("reg_write", 32'(bus.reg_write), 32'(e.v.rw));
    chk("mem_read",  32'(bus.mem_read),  32'(e.v.mr));
    chk("mem_write", 32'(bus.mem_write), 32'(e.v.mw));
    chk("pc", bus.pc, e.pc);
    chk("a",  bus.a,  e.a);
    chk("b",  bus.b,  e.b);
    if (e.v.chk_dp) begin
      chk("alu_op",    32'(bus.alu_op),    32'(e.v.op));
      chk("alu_src_b", 32'(bus.alu_src_b), 32'(e.v.sb));
      chk("is_signed", 32'(bus.is_signed), 32'(e.v.sg));
      chk("rd",        32'(bus.rd),        32'(e.v.rd));
    end
    if (e.v.chk_a)    chk("alu_src_a", 32'(bus.alu_src_a), 32'(e.v.sa));
    if (e.v.chk_sext) chk("sext", bus.sext, e.v.sext);
  endtask

  // One cycle: drive at negedge, push expectation on a handshake, check after posedge.
  task automatic step(input vec_t vv, input logic v, input logic exr, input logic fl,
                      input logic rst);
    logic acc;
    exp_t e;
    @(negedge clk);
    bus.instr = vv.instr; bus.in_pc = $urandom; bus.rs1_data = $urandom;
    bus.rs2_data = $urandom; bus.in_valid = v; bus.ex_ready = exr; flush = fl; rst_n = rst;
    #1;
    if (rst) chk("in_ready", 32'(bus.in_ready), 32'(!ov_m || exr));
    acc = rst && v && (!ov_m || exr) && !fl;
    if (acc) begin
      e.v = vv; e.pc = bus.in_pc; e.a = bus.rs1_data; e.b = bus.rs2_data;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    if (!rst || fl)  ov_m = 1'b0;
    else if (acc)    ov_m = 1'b1;
    else if (exr)    ov_m = 1'b0;
    chk("out_valid", 32'(bus.out_valid), 32'(ov_m));
    if (acc) begin
      if (sb.size() == 0) begin
        chk("sb_nonempty", 32'd0, 32'd1);
      end else begin
        held = sb.pop_front();
        cmp(held);
      end
    end else if (ov_m) begin
      cmp(held);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.ex_ready = 1'b0; bus.instr = 32'd0; bus.in_pc = 32'd0;
    bus.rs1_data = 32'd0; bus.rs2_data = 32'd0; flush = 1'b0; rst_n = 1'b0;

    //              instr         ill   op     sa    sb    sg    sext           rd     rw    mr    mw    cd    ca    cs
    tbl[0]  = mkv(32'hFFF30293, 1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 32'hFFFFFFFF, 5'd5,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    tbl[1]  = mkv(32'h0020E463, 1'b0, 4'd11, 1'b1, 1'b0, 1'b0, 32'h00000008, 5'd8,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    tbl[2]  = mkv(32'h00112023, 1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 32'h00000000, 5'd0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    tbl[3]  = mkv(32'h002081B3, 1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 32'h00000000, 5'd3,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tbl[4]  = mkv(32'h402081B3, 1'b0, 4'd1,  1'b1, 1'b0, 1'b0, 32'h00000000, 5'd3,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tbl[5]  = mkv(32'h4062D233, 1'b0, 4'd6,  1'b1, 1'b0, 1'b0, 32'h00000000, 5'd4,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tbl[6]  = mkv(32'h003120B3, 1'b0, 4'd3,  1'b1, 1'b0, 1'b1, 32'h00000000, 5'd1,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tbl[7]  = mkv(32'h00513093, 1'b0, 4'd3,  1'b1, 1'b1, 1'b0, 32'h00000005, 5'd1,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    tbl[8]  = mkv(32'h40315093, 1'b0, 4'd6,  1'b1, 1'b1, 1'b0, 32'h00000403, 5'd1,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    tbl[9]  = mkv(32'h40311093, 1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 32'h00000000, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[10] = mkv(32'h4020C1B3, 1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 32'h00000000, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[11] = mkv(32'h123453B7, 1'b0, 4'd13, 1'b0, 1'b1, 1'b0, 32'h12345000, 5'd7,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    tbl[12] = mkv(32'h00001097, 1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 32'h00001000, 5'd1,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    tbl[13] = mkv(32'hFFC32283, 1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 32'hFFFFFFFC, 5'd5,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    tbl[14] = mkv(32'h010000EF, 1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 32'h00000010, 5'd1,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    tbl[15] = mkv(32'hFFDFF06F, 1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 32'hFFFFFFFC, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    tbl[16] = mkv(32'h000100E7, 1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 32'h00000000, 5'd1,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    tbl[17] = mkv(32'h000110E7, 1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 32'h00000000, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[18] = mkv(32'hFE208CE3, 1'b0, 4'd9,  1'b1, 1'b0, 1'b0, 32'hFFFFFFF8, 5'd25, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    tbl[19] = mkv(32'h0020D463, 1'b0, 4'd12, 1'b1, 1'b0, 1'b1, 32'h00000008, 5'd8,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    tbl[20] = mkv(32'h0020A463, 1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 32'h00000000, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[21] = mkv(32'hFFFFFFFF, 1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 32'h00000000, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[22] = mkv(32'h00208033, 1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 32'h00000000, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tbl[23] = mkv(32'h0020F1B3, 1'b0, 4'd8,  1'b1, 1'b0, 1'b0, 32'h00000000, 5'd3,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tbl[24] = mkv(32'h0020E1B3, 1'b0, 4'd7,  1'b1, 1'b0, 1'b0, 32'h00000000, 5'd3,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tbl[25] = mkv(32'h0040A003, 1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 32'h00000004, 5'd0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);

    // Reset state.
    step(tbl[0], 1'b1, 1'b1, 1'b0, 1'b0);
    step(tbl[0], 1'b1, 1'b1, 1'b0, 1'b0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_alu_op",    32'(bus.alu_op),    32'd0);
    chk("rst_reg_write", 32'(bus.reg_write), 32'd0);
    chk("rst_illegal",   32'(bus.illegal),   32'd0);
    chk("rst_pc",        bus.pc,             32'd0);
    chk("rst_sext",      bus.sext,           32'd0);

    // Decode table, streamed back-to-back.
    for (int i = 0; i < 26; i++) step(tbl[i], 1'b1, 1'b1, 1'b0, 1'b1);
    step(tbl[0], 1'b0, 1'b1, 1'b0, 1'b1);

    // Stall three cycles with a new word waiting, then release: no bubble.
    step(tbl[0], 1'b1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(tbl[2], 1'b1, 1'b0, 1'b0, 1'b1);
      chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
    end
    step(tbl[2], 1'b1, 1'b1, 1'b0, 1'b1);
    step(tbl[0], 1'b0, 1'b1, 1'b0, 1'b1);

    // Flush coincident with accepting sw.
    step(tbl[2], 1'b1, 1'b1, 1'b1, 1'b1);
    chk("flush_mem_write", 32'(bus.mem_write), 32'd0);

    // Flush while a load is held under stall.
    step(tbl[13], 1'b1, 1'b1, 1'b0, 1'b1);
    step(tbl[0], 1'b0, 1'b0, 1'b1, 1'b1);
    chk("flush_mem_read",  32'(bus.mem_read),  32'd0);
    chk("flush_reg_write", 32'(bus.reg_write), 32'd0);
    chk("flush_in_ready",  32'(bus.in_ready),  32'd1);

    // Reset arriving during a stall discards the held entry.
    step(tbl[0], 1'b1, 1'b1, 1'b0, 1'b1);
    step(tbl[1], 1'b1, 1'b0, 1'b0, 1'b1);
    step(tbl[1], 1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst2_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst2_src_a",     32'(bus.alu_src_a), 32'd0);
    chk("rst2_src_b",     32'(bus.alu_src_b), 32'd0);
    chk("rst2_is_signed", 32'(bus.is_signed), 32'd0);
    chk("rst2_alu_op",    32'(bus.alu_op),    32'd0);
    chk("rst2_pc",        bus.pc,             32'd0);
    chk("rst2_a",         bus.a,              32'd0);
    chk("rst2_b",         bus.b,              32'd0);
    chk("rst2_sext",      bus.sext,           32'd0);
    chk("rst2_rd",        32'(bus.rd),        32'd0);
    chk("rst2_reg_write", 32'(bus.reg_write), 32'd0);
    chk("rst2_mem_read",  32'(bus.mem_read),  32'd0);
    chk("rst2_mem_write", 32'(bus.mem_write), 32'd0);
    chk("rst2_illegal",   32'(bus.illegal),   32'd0);
    step(tbl[3], 1'b1, 1'b1, 1'b0, 1'b1);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
